// File: rtl/pwm_decoder.sv
// PWM decoder: measures high time and period of a PWM input,
// recovers a 4-bit duty code and flags a stuck input.
module pwm_decoder #(
  parameter int TIMEOUT_CYC = 4000
) (
  input  logic        clk_1MHz,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [15:0] high_cycles,
  output logic [15:0] period_cycles,
  output logic [3:0]  duty_code,
  output logic        result_valid,
  output logic        stuck,
  output logic        stuck_level,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic        s1_q, s2_q, hist_q;
  logic        rise, fall, edge_det;
  logic        timeout, done;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] per_q, per_d;
  logic        busy_q, busy_d;
  logic [2:0]  step_q, step_d;
  logic [16:0] rem_q, rem_d, rem_sh;
  logic [15:0] dh_q, dh_d;
  logic [15:0] dp_q, dp_d;
  logic [3:0]  quo_q, quo_d;
  logic [15:0] hc_q, hc_d;
  logic [15:0] pc_q, pc_d;
  logic [3:0]  dc_q, dc_d;
  logic        rv_q, rv_d;
  logic        st_q, st_d;
  logic        lv_q, lv_d;
  logic        ov_q, ov_d;

  assign rise     = s2_q & ~hist_q;
  assign fall     = ~s2_q & hist_q;
  assign edge_det = s2_q ^ hist_q;
  assign timeout  = ~edge_det &
                    (tmo_q == TMO - 16'd1);

  assign high_cycles   = hc_q;
  assign period_cycles = pc_q;
  assign duty_code     = dc_q;
  assign result_valid  = rv_q;
  assign stuck         = st_q;
  assign stuck_level   = lv_q;
  assign overrun       = ov_q;

  // Two-stage synchroniser plus history bit for edge detection
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= pwm_in;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; a rise seen in LOW closes one period
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    if (timeout) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (rise) state_d = HIGH;
        HIGH: if (fall) state_d = LOW;
        LOW: begin
          if (rise) begin
            state_d = HIGH;
            done    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Edge-age, high-time and period counters
  always_comb begin
    tmo_d = tmo_q;
    hi_d  = hi_q;
    per_d = per_q;
    if (edge_det)         tmo_d = '0;
    else if (tmo_q != TMO) tmo_d = tmo_q + 16'd1;
    if (timeout) begin
      hi_d  = '0;
      per_d = '0;
    end else if (rise) begin
      hi_d  = 16'd1;
      per_d = 16'd1;
    end else begin
      if (state_q == HIGH && !fall)
        hi_d = hi_q + 16'd1;
      if (state_q != IDLE)
        per_d = per_q + 16'd1;
    end
  end

  // Divider steps, result publication and stuck reporting
  always_comb begin
    busy_d = busy_q;
    step_d = step_q;
    rem_d  = rem_q;
    dh_d   = dh_q;
    dp_d   = dp_q;
    quo_d  = quo_q;
    hc_d   = hc_q;
    pc_d   = pc_q;
    dc_d   = dc_q;
    st_d   = st_q;
    lv_d   = lv_q;
    rv_d   = 1'b0;
    ov_d   = 1'b0;
    rem_sh = rem_q << 1;
    if (timeout) begin
      busy_d = 1'b0;
      step_d = '0;
      hc_d   = '0;
      pc_d   = '0;
      dc_d   = {4{s2_q}};
      st_d   = 1'b1;
      lv_d   = s2_q;
      rv_d   = 1'b1;
    end else begin
      if (edge_det) begin
        st_d = 1'b0;
        lv_d = 1'b0;
      end
      if (busy_q) begin
        if (step_q == 3'd4) begin
          busy_d = 1'b0;
          hc_d   = dh_q;
          pc_d   = dp_q;
          dc_d   = quo_q;
          rv_d   = 1'b1;
        end else begin
          step_d = step_q + 3'd1;
          if (rem_sh >= {1'b0, dp_q}) begin
            rem_d = rem_sh - {1'b0, dp_q};
            quo_d = {quo_q[2:0], 1'b1};
          end else begin
            rem_d = rem_sh;
            quo_d = {quo_q[2:0], 1'b0};
          end
        end
      end
      if (done) begin
        if (busy_q) begin
          ov_d = 1'b1;
        end else begin
          busy_d = 1'b1;
          step_d = '0;
          rem_d  = {1'b0, hi_q};
          dh_d   = hi_q;
          dp_d   = per_q;
          quo_d  = '0;
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q  <= '0;
      hi_q   <= '0;
      per_q  <= '0;
      busy_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      dh_q   <= '0;
      dp_q   <= '0;
      quo_q  <= '0;
      hc_q   <= '0;
      pc_q   <= '0;
      dc_q   <= '0;
      rv_q   <= 1'b0;
      st_q   <= 1'b0;
      lv_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      hi_q   <= hi_d;
      per_q  <= per_d;
      busy_q <= busy_d;
      step_q <= step_d;
      rem_q  <= rem_d;
      dh_q   <= dh_d;
      dp_q   <= dp_d;
      quo_q  <= quo_d;
      hc_q   <= hc_d;
      pc_q   <= pc_d;
      dc_q   <= dc_d;
      rv_q   <= rv_d;
      st_q   <= st_d;
      lv_q   <= lv_d;
      ov_q   <= ov_d;
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: table of waveform shapes, corner sequences
// and random pulse trains against an event-level reference model.
`timescale 1ns/1ps
module tb_pwm_decoder;

  localparam int T = 4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwm_in;
  logic [15:0] high_cycles;
  logic [15:0] period_cycles;
  logic [3:0]  duty_code;
  logic        result_valid;
  logic        stuck;
  logic        stuck_level;
  logic        overrun;

  pwm_decoder dut (
    .clk_1MHz     (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .high_cycles  (high_cycles),
    .period_cycles(period_cycles),
    .duty_code    (duty_code),
    .result_valid (result_valid),
    .stuck        (stuck),
    .stuck_level  (stuck_level),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int h; int p; int d; int st; int lv;
  } ev_t;

  typedef struct {
    int hi; int lo; int h; int p; int d;
  } vec_t;

  ev_t  exp_rv[int];
  bit   exp_ov[int];
  bit   exp_st[int];
  vec_t tbl[9];

  int   n_chk = 0;
  int   n_fail = 0;
  int   rv_cnt = 0;
  int   ov_cnt = 0;
  int   last_h, last_p, last_d;

  // model state: detect-edge times of the waveform
  logic cur_lvl;
  int   pe, rises, prev_rise, hi_start, hi_len, acc_d;

  task automatic chk(input string nm, input int act,
                     input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, want %0d",
               nm, edge_n, act, want);
    end
  endtask

  task automatic model_reset();
    ev_t e;
    exp_rv.delete();
    exp_ov.delete();
    exp_st.delete();
    rises   = 0;
    acc_d   = -100;
    cur_lvl = 1'b0;
    pe      = edge_n + T;
    e       = '{0, 0, 0, 1, 0};
    exp_rv[pe] = e;
  endtask

  // input changes at sample edge_n+1, seen by the DUT 2 edges later
  task automatic model_edge(input logic lvl);
    ev_t e;
    int  d;
    d = edge_n + 3;
    if (d > pe) begin
      rises = 0;
      exp_st[d] = 1'b1;
    end else begin
      exp_rv.delete(pe);
    end
    if (lvl) begin
      if (rises > 0) begin
        if (d - acc_d <= 5) begin
          exp_ov[d] = 1'b1;
        end else begin
          e.h  = hi_len;
          e.p  = d - prev_rise;
          e.d  = 16 * hi_len / e.p;
          e.st = 0;
          e.lv = 0;
          exp_rv[d + 5] = e;
          acc_d = d;
        end
      end
      rises++;
      prev_rise = d;
      hi_start  = d;
    end else begin
      hi_len = d - hi_start;
    end
    pe = d + T;
    e  = '{0, 0, (lvl ? 15 : 0), 1, int'(lvl)};
    exp_rv[pe] = e;
    cur_lvl = lvl;
  endtask

  task automatic seg(input logic lvl, input int len);
    if (lvl !== cur_lvl) model_edge(lvl);
    pwm_in = lvl;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_high"},   int'(high_cycles), 0);
    chk({tag, "_period"}, int'(period_cycles), 0);
    chk({tag, "_duty"},   int'(duty_code), 0);
    chk({tag, "_valid"},  int'(result_valid), 0);
    chk({tag, "_stuck"},  int'(stuck), 0);
    chk({tag, "_level"},  int'(stuck_level), 0);
    chk({tag, "_ovr"},    int'(overrun), 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        int k;
        k = edge_n;
        if (result_valid) begin
          rv_cnt++;
          last_h = int'(high_cycles);
          last_p = int'(period_cycles);
          last_d = int'(duty_code);
        end
        if (result_valid || exp_rv.exists(k)) begin
          chk("rv_strobe", int'(result_valid),
              int'(exp_rv.exists(k)));
          if (result_valid && exp_rv.exists(k)) begin
            chk("rv_high",   int'(high_cycles), exp_rv[k].h);
            chk("rv_period", int'(period_cycles), exp_rv[k].p);
            chk("rv_duty",   int'(duty_code), exp_rv[k].d);
            chk("rv_stuck",  int'(stuck), exp_rv[k].st);
            chk("rv_level",  int'(stuck_level), exp_rv[k].lv);
          end
          if (exp_rv.exists(k)) exp_rv.delete(k);
        end
        if (overrun) ov_cnt++;
        if (overrun || exp_ov.exists(k)) begin
          chk("ovr_strobe", int'(overrun),
              int'(exp_ov.exists(k)));
          if (exp_ov.exists(k)) exp_ov.delete(k);
        end
        if (exp_st.exists(k)) begin
          chk("stuck_clear", int'(stuck), 0);
          exp_st.delete(k);
        end
      end
    end
  endtask

  initial begin
    int c0;
    tbl[0] = '{1000, 1000, 1000, 2000, 8};
    tbl[1] = '{125, 1875, 125, 2000, 1};
    tbl[2] = '{1875, 125, 1875, 2000, 15};
    tbl[3] = '{3, 6, 3, 9, 5};
    tbl[4] = '{1, 15, 1, 16, 1};
    tbl[5] = '{15, 1, 15, 16, 15};
    tbl[6] = '{7, 9, 7, 16, 7};
    tbl[7] = '{10, 10, 10, 20, 8};
    tbl[8] = '{5, 11, 5, 16, 5};

    rst_n  = 1'b0;
    pwm_in = 1'b0;
    fork
      monitor();
    join_none
    repeat (4) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    model_reset();
    seg(1'b0, 3);

    // shape table: three periods each
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 3; j++) begin
        seg(1'b1, tbl[i].hi);
        seg(1'b0, tbl[i].lo);
      end
      chk("tbl_high",   last_h, tbl[i].h);
      chk("tbl_period", last_p, tbl[i].p);
      chk("tbl_duty",   last_d, tbl[i].d);
    end

    // held low past the timeout
    seg(1'b1, 50);
    c0 = rv_cnt;
    seg(1'b0, 4300);
    chk("lo_stuck",   int'(stuck), 1);
    chk("lo_level",   int'(stuck_level), 0);
    chk("lo_duty",    int'(duty_code), 0);
    chk("lo_high",    int'(high_cycles), 0);
    chk("lo_period",  int'(period_cycles), 0);
    chk("lo_pulses",  rv_cnt - c0, 1);
    seg(1'b1, 10);
    chk("lo_release", int'(stuck), 0);
    seg(1'b0, 10);

    // held high past the timeout
    seg(1'b1, 4100);
    chk("hi_stuck", int'(stuck), 1);
    chk("hi_level", int'(stuck_level), 1);
    chk("hi_duty",  int'(duty_code), 15);
    seg(1'b0, 20);
    chk("hi_release", int'(stuck), 0);
    c0 = rv_cnt;
    seg(1'b1, 20);
    seg(1'b0, 20);
    chk("hi_first_rise", rv_cnt - c0, 0);
    seg(1'b1, 20);
    seg(1'b0, 20);
    chk("hi_second_rise", rv_cnt - c0, 1);
    chk("hi_after_duty",  last_d, 8);

    // 2/2 waveform: divider busy on every other rise
    c0 = ov_cnt;
    for (int i = 0; i < 20; i++) begin
      seg(1'b1, 2);
      seg(1'b0, 2);
    end
    chk("fast_ovr_seen", int'(ov_cnt - c0 >= 9), 1);
    chk("fast_high",   last_h, 2);
    chk("fast_period", last_p, 4);
    chk("fast_duty",   last_d, 8);

    // reset pulsed while the input is high
    seg(1'b1, 30);
    seg(1'b0, 30);
    seg(1'b1, 30);
    seg(1'b0, 30);
    seg(1'b1, 15);
    chk("pre_rst_high", int'(high_cycles), 30);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    c0 = rv_cnt;
    seg(1'b1, 20);
    seg(1'b0, 20);
    chk("rst_first_rise", rv_cnt - c0, 0);
    seg(1'b1, 20);
    chk("rst_second_rise", rv_cnt - c0, 1);
    chk("rst_high",   last_h, 20);
    chk("rst_period", last_p, 40);
    chk("rst_duty",   last_d, 8);
    seg(1'b0, 20);

    // random pulse trains
    for (int i = 0; i < 150; i++) begin
      seg(1'b1, int'($urandom_range(1, 12)));
      seg(1'b0, int'($urandom_range(1, 12)));
    end
    seg(1'b0, 30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL take parameter TIMEOUT_CYC, default 4000: the number of cycles without any input edge after which the input is declared stuck; legal range 16..32767.
REQ-002 SHALL have port clk_1MHz, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port pwm_in, input, 1 bit: the PWM waveform to measure, asynchronous to clk_1MHz.
REQ-005 SHALL have port high_cycles, output, 16 bits: the high time of the last completed period, in clock cycles.
REQ-006 SHALL have port period_cycles, output, 16 bits: rising-to-rising period of the last completed period, in clock cycles.
REQ-007 SHALL have port duty_code, output, 4 bits: the recovered 4-bit pulse width.
REQ-008 SHALL have port result_valid, output, 1 bit: a one-cycle strobe that outputs were updated.
REQ-009 SHALL have port stuck, output, 1 bit: a level; the input has been static for TIMEOUT_CYC cycles.
REQ-010 SHALL have port stuck_level, output, 1 bit: the static input value while stuck=1.
REQ-011 SHALL have port overrun, output, 1 bit: a one-cycle strobe that a measurement was dropped.

Function
REQ-012 SHALL synchronise pwm_in through 2 flip-flops plus 1 history flip-flop; an edge is detected one cycle after it leaves stage 2 (pwm_in sampled at clock edge N -> edge detected at edge N+2).
REQ-013 SHALL implement the FSM states IDLE, HIGH and LOW; IDLE->HIGH on a detected rise; HIGH->LOW on a detected fall; LOW->HIGH on a detected rise, which completes a measurement; any state->IDLE on timeout.
REQ-014 SHALL count in high_cnt every synchronised-high cycle from the rise-detect cycle (counting 1) up to the fall-detect cycle (not counted); period_cnt SHALL count every cycle from the rise-detect cycle to the next rise-detect cycle (not counted).
REQ-015 On measurement completion, SHALL latch H=high_cnt and P=period_cnt into the divider and restart both counters at 1 in the same cycle; the FSM never stalls.
REQ-016 SHALL run the divider as a 4-step restoring divider, one quotient bit per cycle, MSB first: r starts at H (17 bits); each step r=2r and, if r>=P, r=r-P and the bit is 1; duty_code=floor(16*H/P), always <=15.
REQ-017 SHALL assert result_valid for exactly one cycle, 5 clocks after the completing rise-detect; high_cycles, period_cycles and duty_code SHALL update in that same cycle and hold until the next update.
REQ-018 If a measurement completes while the divider is busy, SHALL drop the new measurement, pulse overrun for 1 cycle and leave the in-flight result undisturbed; counters still restart.
REQ-019 SHALL count cycles since the last detected edge of either polarity in a timeout counter; when it reaches TIMEOUT_CYC: stuck=1, stuck_level=synchronised input, high_cycles=0, period_cycles=0, duty_code=0 if low / 15 if high, one result_valid pulse, FSM->IDLE, counters cleared; any in-flight division is discarded.
REQ-020 SHALL hold the timeout counter at TIMEOUT_CYC while stuck, with no further result_valid pulses.
REQ-021 SHALL clear stuck on the next detected edge of either polarity; the next result SHALL need a full rise-to-rise period.
REQ-022 SHALL not emit a result for the first rise after reset or stuck; the first result comes at the second rise.

Reset
REQ-023 When rst_n=0, SHALL immediately force all outputs to 0, the FSM to IDLE, the synchroniser, counters and divider to 0, and the divider to not busy.
REQ-024 Deassertion mid-waveform SHALL behave as if the input had just been observed, with no spurious edge from the zeroed synchroniser unless pwm_in is high, in which case a rise is detected.

Verification
REQ-025 SHALL pass: high 1000/low 1000 cycles, repeating -> result_valid 5 cycles after each rise from the 2nd; high_cycles=1000, period_cycles=2000, duty_code=8.
REQ-026 SHALL pass: high 125/low 1875, then high 1875/low 125 -> duty_code=1, then duty_code=15; period_cycles=2000 both.
REQ-027 SHALL pass: pwm_in held low 4000 cycles after a rise/fall -> stuck=1, stuck_level=0, duty_code=0, single result_valid; then a rise -> stuck=0.
REQ-028 SHALL pass: pwm_in held high past timeout -> stuck=1, stuck_level=1, duty_code=15.
REQ-029 SHALL pass: high 2/low 2 repeating -> overrun on alternate completing rises; accepted results show high_cycles=2, period_cycles=4, duty_code=8.
REQ-030 SHALL pass: rst_n pulsed low mid-HIGH -> outputs 0 at once; the first result after release needs two further rises.
